wb_arb_rr: RTL

- Round-robin Wishbone arbiter that shares one WB slave port between p_N WB masters.
- Typical slave is a PIO block with a 4-bit byte address and 32-bit data.
- Grants the bus for a whole cycle (CYC-held burst), routes ACK and read data back to the owner, and breaks hung cycles with a timeout that returns ERR.
- Sits between the CPU/DMA masters and the peripheral slave.

---
 rtl/wb_arb_rr.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone arbiter: p_N masters share one slave port; a grant lasts a whole CYC-held cycle.
// Latency: request to slave STB is 1 cycle. Slave strobes, ACK and read data are combinational once granted.
// Backpressure: a cycle is held until the owner drops CYC; a stalled STB is ended with an ERR pulse after p_TO cycles.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   iv_wbm_*                packed per-master Wishbone inputs (bit/field k = master k)
//   ov_wbm_dat              slave read data, broadcast to every master
//   ov_wbm_ack/ov_wbm_err   per-master ACK / ERR, only ever driven to the owner
//   ov_wbs_* / o_wbs_*      slave-side Wishbone outputs, muxed from the owner
//   iv_wbs_dat, i_wbs_ack   slave read data and ACK
//   ov_gnt                  registered one-hot owner (zero while idle)
module wb_arb_rr #(
  parameter int p_N  = 2,
  parameter int p_AW = 4,
  parameter int p_TO = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [p_N-1:0]       iv_wbm_cyc,
  input  logic [p_N-1:0]       iv_wbm_stb,
  input  logic [p_N-1:0]       iv_wbm_we,
  input  logic [p_N*p_AW-1:0]  iv_wbm_adr,
  input  logic [p_N*32-1:0]    iv_wbm_dat,
  input  logic [p_N*4-1:0]     iv_wbm_sel,
  output logic [31:0]          ov_wbm_dat,
  output logic [p_N-1:0]       ov_wbm_ack,
  output logic [p_N-1:0]       ov_wbm_err,
  output logic [p_AW-1:0]      ov_wbs_adr,
  output logic [31:0]          ov_wbs_dat,
  output logic                 o_wbs_we,
  output logic                 o_wbs_stb,
  output logic [3:0]           ov_wbs_sel,
  output logic                 o_wbs_cyc,
  input  logic [31:0]          iv_wbs_dat,
  input  logic                 i_wbs_ack,
  output logic [p_N-1:0]       ov_gnt
);

  localparam int IW = (p_N > 1) ? $clog2(p_N) : 1;
  localparam int WW = $clog2(p_TO);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [p_N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [WW-1:0]    wd_q, wd_d;

  // Per-master views of the packed input buses.
  logic [p_AW-1:0]  adr_a [p_N];
  logic [31:0]      dat_a [p_N];
  logic [3:0]       sel_a [p_N];

  for (genvar k = 0; k < p_N; k++) begin : g_unpack
    assign adr_a[k] = iv_wbm_adr[k*p_AW +: p_AW];
    assign dat_a[k] = iv_wbm_dat[k*32 +: 32];
    assign sel_a[k] = iv_wbm_sel[k*4 +: 4];
  end

  logic own_cyc;
  logic own_stb;

  assign own_cyc = iv_wbm_cyc[idx_q];
  assign own_stb = iv_wbm_stb[idx_q];

  // Address/data/select always follow the current owner index; they are
  // only meaningful to the slave while CYC/STB are asserted.
  assign ov_wbs_adr = adr_a[idx_q];
  assign ov_wbs_dat = dat_a[idx_q];
  assign ov_wbs_sel = sel_a[idx_q];
  assign o_wbs_we   = iv_wbm_we[idx_q];
  assign ov_wbm_dat = iv_wbs_dat;
  assign ov_gnt     = gnt_q;

  // Round-robin pick: first requester after the last winner, with wrap.
  // The scan ends on last_q itself, so a lone re-requester still wins.
  logic          req_vld;
  logic [IW-1:0] req_sel;
  logic [IW-1:0] cand;

  always_comb begin
    req_vld = 1'b0;
    req_sel = last_q;
    cand    = '0;
    for (int i = 1; i <= p_N; i++) begin
      cand = IW'((int'(last_q) + i) % p_N);
      if (!req_vld && iv_wbm_cyc[cand]) begin
        req_vld = 1'b1;
        req_sel = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    wd_d       = wd_q;
    o_wbs_cyc  = 1'b0;
    o_wbs_stb  = 1'b0;
    ov_wbm_ack = '0;
    ov_wbm_err = '0;

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (req_vld) begin
          state_d        = ST_BUSY;
          idx_d          = req_sel;
          last_d         = req_sel;
          gnt_d          = '0;
          gnt_d[req_sel] = 1'b1;
        end
      end

      ST_BUSY: begin
        o_wbs_cyc = own_cyc;
        o_wbs_stb = own_cyc & own_stb;
        // ACK is only meaningful against an active strobe.
        ov_wbm_ack[idx_q] = i_wbs_ack & own_cyc & own_stb;
        if (!own_cyc) begin
          // Always pass through IDLE before the next grant.
          state_d = ST_IDLE;
          gnt_d   = '0;
          wd_d    = '0;
        end else if (own_stb && !i_wbs_ack) begin
          if (wd_q == WW'(p_TO - 1)) begin
            state_d = ST_ERR;
            wd_d    = '0;
          end else begin
            wd_d = wd_q + WW'(1);
          end
        end else begin
          wd_d = '0;
        end
      end

      ST_ERR: begin
        // One-cycle error pulse; slave is released and any late ACK dropped.
        ov_wbm_err[idx_q] = 1'b1;
        state_d           = ST_IDLE;
        gnt_d             = '0;
        wd_d              = '0;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IW'(p_N - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule
